// File: rtl/dma_bus_engine.sv
// dma_bus_engine: block DMA between the system bus and port B of the CI scratch memory.
// Multi-word bursts only when DMA_BUS_ENGINE_BURST_EN is defined, otherwise one word per transaction.
module dma_bus_engine #(
  parameter int MEM_ADDR_BITS = 9,
  parameter int MAX_BURST = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cfg_we_i,
  input  logic [2:0]               cfg_sel_i,
  input  logic [31:0]              cfg_data_i,
  output logic [1:0]               status_o,
  output logic [MEM_ADDR_BITS-1:0] sram_address_o,
  output logic                     sram_write_enable_o,
  output logic [31:0]              sram_data_o,
  input  logic [31:0]              sram_data_i,
  output logic                     request_bus_o,
  input  logic                     bus_grant_i,
  output logic                     begin_transaction_o,
  output logic [31:0]              address_data_o,
  output logic                     read_not_write_o,
  output logic [7:0]               burst_size_o,
  output logic [3:0]               byte_enables_o,
  output logic                     data_valid_o,
  output logic                     end_transaction_o,
  input  logic [31:0]              address_data_i,
  input  logic                     data_valid_i,
  input  logic                     end_transaction_i,
  input  logic                     busy_i,
  input  logic                     bus_error_i
);
`ifdef DMA_BUS_ENGINE_BURST_EN
  localparam bit BurstEn = 1'b1;
`else
  localparam bit BurstEn = 1'b0;
`endif
  localparam logic [MEM_ADDR_BITS-1:0] MemOne = 1;
  typedef enum logic [2:0] {IDLE, REQUEST, BEGIN, READ, WRITE, NEXT} state_e;
  state_e state_q, state_d;
  logic [31:0] bus_start_q, bus_addr_q, bus_addr_d;
  logic [MEM_ADDR_BITS-1:0] mem_start_q, mem_addr_q, mem_addr_d;
  logic [9:0] block_size_q, remain_q, remain_d, cnt_q, cnt_d, max_n, n;
  logic [7:0] burst_size_q;
  logic dir_q, dir_d, err_q, err_d, start, accept;
  assign max_n = BurstEn ? ((burst_size_q > 8'(MAX_BURST - 1)) ? 10'(MAX_BURST) : {2'b00, burst_size_q} + 10'd1) : 10'd1;
  assign n = (remain_q < max_n) ? remain_q : max_n;
  assign start = cfg_we_i && state_q == IDLE && cfg_sel_i == 3'd4 && (cfg_data_i[0] || cfg_data_i[1]) && block_size_q != 10'd0;
  assign accept = data_valid_o && !busy_i;
  assign status_o = {err_q, state_q != IDLE};
  assign request_bus_o = state_q == REQUEST || state_q == BEGIN || state_q == READ || state_q == WRITE;
  assign begin_transaction_o = state_q == BEGIN;
  assign read_not_write_o = (state_q == BEGIN || state_q == READ) && dir_q;
  assign burst_size_o = (state_q == BEGIN) ? 8'(n - 10'd1) : 8'd0;
  assign byte_enables_o = (state_q == BEGIN || state_q == READ || state_q == WRITE) ? 4'hF : 4'h0;
  assign data_valid_o = state_q == WRITE && cnt_q != n;
  assign end_transaction_o = state_q == WRITE && (cnt_q == n || bus_error_i);
  assign address_data_o = (state_q == BEGIN) ? bus_addr_q : data_valid_o ? sram_data_i : 32'd0;
  assign sram_write_enable_o = state_q == READ && data_valid_i && !bus_error_i;
  assign sram_data_o = sram_write_enable_o ? address_data_i : 32'd0;
  // Presents next word's address on acceptance so its data is ready the following cycle
  assign sram_address_o = accept ? mem_addr_q + MemOne : mem_addr_q;
  always_comb begin
    state_d = state_q;
    bus_addr_d = bus_addr_q;
    mem_addr_d = mem_addr_q;
    remain_d = remain_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    err_d = err_q;
    if (bus_error_i && state_q != IDLE) begin
      state_d = IDLE;
      err_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = REQUEST;
          bus_addr_d = bus_start_q;
          mem_addr_d = mem_start_q;
          remain_d = block_size_q;
          dir_d = cfg_data_i[0];
          err_d = 1'b0;
        end
        REQUEST: state_d = bus_grant_i ? BEGIN : REQUEST;
        BEGIN: begin
          state_d = dir_q ? READ : WRITE;
          cnt_d = 10'd0;
        end
        READ: begin
          mem_addr_d = data_valid_i ? mem_addr_q + MemOne : mem_addr_q;
          state_d = end_transaction_i ? NEXT : READ;
        end
        WRITE: begin
          mem_addr_d = accept ? mem_addr_q + MemOne : mem_addr_q;
          cnt_d = accept ? cnt_q + 10'd1 : cnt_q;
          state_d = (cnt_q == n) ? NEXT : WRITE;
        end
        NEXT: begin
          bus_addr_d = bus_addr_q + {20'd0, n, 2'b00};
          remain_d = remain_q - n;
          state_d = (remain_q == n) ? IDLE : REQUEST;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      bus_start_q <= 32'd0;
      mem_start_q <= '0;
      block_size_q <= 10'd0;
      burst_size_q <= 8'd0;
      bus_addr_q <= 32'd0;
      mem_addr_q <= '0;
      remain_q <= 10'd0;
      cnt_q <= 10'd0;
      dir_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bus_addr_q <= bus_addr_d;
      mem_addr_q <= mem_addr_d;
      remain_q <= remain_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      err_q <= err_d;
      if (cfg_we_i && state_q == IDLE) begin
        if (cfg_sel_i == 3'd0) bus_start_q <= {cfg_data_i[31:2], 2'b00};
        if (cfg_sel_i == 3'd1) mem_start_q <= cfg_data_i[MEM_ADDR_BITS-1:0];
        if (cfg_sel_i == 3'd2) block_size_q <= cfg_data_i[9:0];
        if (cfg_sel_i == 3'd3) burst_size_q <= cfg_data_i[7:0];
      end
    end
  end
endmodule

// File: tb/tb_dma_bus_engine.sv
// tb_dma_bus_engine: directed bench with scoreboard queues for bus begins, memory writes and bus write data.
module tb_dma_bus_engine;
`ifdef DMA_BUS_ENGINE_BURST_EN
  localparam bit BE = 1'b1;
`else
  localparam bit BE = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_we = 1'b0;
  logic [2:0] cfg_sel = 3'd0;
  logic [31:0] cfg_data = 32'd0;
  logic [1:0] status;
  logic [8:0] sram_addr;
  logic sram_we;
  logic [31:0] sram_wdata, sram_rdata;
  logic req, bt, rnw, dvo, eto;
  logic grant = 1'b0;
  logic [31:0] ado;
  logic [7:0] bso;
  logic [3:0] beo;
  logic [31:0] adi = 32'd0;
  logic dvi = 1'b0, eti = 1'b0, busy = 1'b0, berr = 1'b0;
  logic [31:0] mem [512];
  logic [92:0] outs;
  int n_chk = 0, n_fail = 0;
  logic [40:0] bq[$];
  logic [40:0] sq[$];
  logic [31:0] wq[$];
  logic [40:0] me;
  logic [31:0] mw;
  always #5 clk = ~clk;
  dma_bus_engine dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(cfg_we), .cfg_sel_i(cfg_sel), .cfg_data_i(cfg_data),
    .status_o(status), .sram_address_o(sram_addr), .sram_write_enable_o(sram_we),
    .sram_data_o(sram_wdata), .sram_data_i(sram_rdata), .request_bus_o(req), .bus_grant_i(grant),
    .begin_transaction_o(bt), .address_data_o(ado), .read_not_write_o(rnw), .burst_size_o(bso),
    .byte_enables_o(beo), .data_valid_o(dvo), .end_transaction_o(eto), .address_data_i(adi),
    .data_valid_i(dvi), .end_transaction_i(eti), .busy_i(busy), .bus_error_i(berr)
  );
  assign outs = {status, sram_addr, sram_we, sram_wdata, req, bt, ado, rnw, bso, beo, dvo, eto};
  function automatic logic [31:0] init_w(input int a);
    return 32'hC0DE_0000 + 32'(a * 7);
  endfunction
  function automatic int blen(input int rem, input int burst);
    int m;
    m = BE ? ((burst > 15) ? 16 : burst + 1) : 1;
    return (rem < m) ? rem : m;
  endfunction
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Port B model: one-cycle read latency, reloaded with a known pattern while reset is low
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_w(i);
    end else if (sram_we) mem[sram_addr] <= sram_wdata;
    sram_rdata <= mem[sram_addr];
  end
  always @(negedge clk) begin
    if (bt) begin
      chk("bt_expected", 128'(bq.size() != 0), 128'(1));
      if (bq.size() != 0) begin
        me = bq.pop_front();
        chk("bt_addr", ado, me[40:9]);
        chk("bt_burst", bso, me[8:1]);
        chk("bt_rnw", rnw, me[0]);
        chk("bt_be", beo, 4'hF);
      end
    end
    if (sram_we) begin
      chk("sram_expected", 128'(sq.size() != 0), 128'(1));
      if (sq.size() != 0) begin
        me = sq.pop_front();
        chk("sram_addr", sram_addr, me[40:32]);
        chk("sram_data", sram_wdata, me[31:0]);
      end
    end
    if (dvo && !busy) begin
      chk("wdata_expected", 128'(wq.size() != 0), 128'(1));
      if (wq.size() != 0) begin
        mw = wq.pop_front();
        chk("wdata", ado, mw);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input logic [2:0] s, input logic [31:0] d);
    cfg_we = 1'b1;
    cfg_sel = s;
    cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask
  task automatic wait_req();
    int k = 0;
    while (!req && k < 40) begin
      tick();
      k++;
    end
    chk("req_wait", req, 1'b1);
  endtask
  task automatic do_read(input logic [31:0] bus, input int memst, input int len, input int burst, input int err_at, input int ctl);
    int rem, idx, n;
    logic [31:0] d;
    cfg(3'd0, bus); cfg(3'd1, 32'(memst)); cfg(3'd2, 32'(len)); cfg(3'd3, 32'(burst)); cfg(3'd4, 32'(ctl));
    chk("rd_busy", status, 2'b01);
    rem = len;
    idx = 0;
    while (rem > 0) begin
      n = blen(rem, burst);
      bq.push_back({bus, 8'(n - 1), 1'b1});
      wait_req();
      grant = 1'b1;
      tick();
      grant = 1'b0;
      tick();
      for (int i = 0; i < n; i++) begin
        if (idx == err_at) begin
          berr = 1'b1;
          tick();
          berr = 1'b0;
          chk("err_status", status, 2'b10);
          chk("err_req", req, 1'b0);
          return;
        end
        d = $urandom;
        adi = d;
        dvi = 1'b1;
        eti = (i == n - 1);
        sq.push_back({9'(memst + idx), d});
        tick();
        dvi = 1'b0;
        eti = 1'b0;
        idx++;
      end
      chk("rd_next_req_drop", req, 1'b0);
      tick();
      bus += 32'(4 * n);
      rem -= n;
    end
    chk("rd_done_status", status, 2'b00);
  endtask
  task automatic do_write(input logic [31:0] bus, input int memst, input int len, input int burst, input bit stall);
    int rem, idx, n, acc, k, st;
    bit stalled = 1'b0;
    cfg(3'd0, bus); cfg(3'd1, 32'(memst)); cfg(3'd2, 32'(len)); cfg(3'd3, 32'(burst)); cfg(3'd4, 32'd2);
    chk("wr_busy", status, 2'b01);
    rem = len;
    idx = 0;
    while (rem > 0) begin
      n = blen(rem, burst);
      bq.push_back({bus, 8'(n - 1), 1'b0});
      for (int i = 0; i < n; i++) wq.push_back(init_w((memst + idx + i) % 512));
      wait_req();
      grant = 1'b1;
      tick();
      grant = 1'b0;
      tick();
      chk("wr_first_dv", dvo, 1'b1);
      acc = 0;
      k = 0;
      st = 0;
      while (!eto && k < 60) begin
        if (stall && !stalled && dvo && idx + acc == 2) begin
          st = 3;
          stalled = 1'b1;
        end
        busy = (st > 0);
        #1;
        if (st > 0) begin
          chk("stall_dv", dvo, 1'b1);
          chk("stall_hold", ado, (wq.size() != 0) ? wq[0] : 32'd0);
          st--;
        end else if (dvo) acc++;
        tick();
        k++;
      end
      busy = 1'b0;
      chk("wr_end", eto, 1'b1);
      chk("wr_end_dv", dvo, 1'b0);
      chk("wr_count", acc, n);
      tick();
      chk("wr_next_req_drop", req, 1'b0);
      tick();
      bus += 32'(4 * n);
      rem -= n;
      idx += n;
    end
    chk("wr_done_status", status, 2'b00);
  endtask
  initial begin
    int n;
    repeat (2) tick();
    chk("rst_outs", outs, 0);
    chk("rst_status", status, 2'b00);
    rst_n = 1'b1;
    tick();
    do_read(32'h0000_1000, 'h10, 8, 3, -1, 1);
    do_write(32'h0000_2000, 'h1FE, 5, 15, 1'b0);
    do_write(32'h0000_3000, 'h40, 6, 7, 1'b1);
    do_read(32'h0000_7000, 'h180, 18, 200, -1, 1);
    do_read(32'hFFFF_FFF8, 'h100, 4, 1, -1, 3);
    cfg(3'd2, 32'd0);
    cfg(3'd4, 32'd1);
    chk("zero_req_now", req, 1'b0);
    tick();
    chk("zero_req", req, 1'b0);
    chk("zero_status", status, 2'b00);
    do_read(32'h0000_4000, 'h80, 4, 3, 1, 1);
    do_read(32'h0000_4800, 'h90, 3, 3, -1, 1);
    cfg(3'd0, 32'h0000_5000); cfg(3'd1, 32'h20); cfg(3'd2, 32'd4); cfg(3'd3, 32'd3); cfg(3'd4, 32'd2);
    n = blen(4, 3);
    bq.push_back({32'h0000_5000, 8'(n - 1), 1'b0});
    wait_req();
    grant = 1'b1;
    tick();
    grant = 1'b0;
    tick();
    chk("rst_pre_dv", dvo, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", outs, 0);
    bq.delete();
    sq.delete();
    wq.delete();
    tick();
    rst_n = 1'b1;
    tick();
    do_read(32'h0000_6000, 'h30, 6, 2, -1, 1);
    chk("bq_drained", bq.size(), 0);
    chk("sq_drained", sq.size(), 0);
    chk("wq_drained", wq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
